signed_sequential_divider: RTL

//  Multi-cycle signed integer divider; the inverse datapath of the chip's signed multiplier.

---
 rtl/signed_sequential_divider.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/signed_sequential_divider.sv
// Signed restoring divider, one quotient bit per clock.
// Ports: clk, rst, start, dividend, divisor -> busy, done, quotient, remainder, div_by_zero, overflow.
module signed_sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_ZERO,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_ovf;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;
  logic             r_ov;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_dz_in;
  logic             w_min;

  assign w_dvd_mag = dividend[WIDTH-1] ?
                     (~dividend + WIDTH'(1)) : dividend;
  assign w_dvs_mag = divisor[WIDTH-1] ?
                     (~divisor + WIDTH'(1)) : divisor;
  assign w_dz_in   = (divisor == '0);
  assign w_min     = (dividend == {1'b1, {(WIDTH-1){1'b0}}});

  // Partial remainder stays below the divisor magnitude,
  // so the shifted value never exceeds WIDTH bits and bit
  // WIDTH of the difference is a valid borrow.
  assign w_shift = {r_rem, r_mag[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = w_dz_in ? S_ZERO : S_CALC;
      end
      S_CALC: begin
        if (r_cnt == CW'(1)) w_next = S_FIX;
      end
      S_FIX:   w_next = S_DONE;
      S_ZERO:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dz    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      // done is a registered copy of the DONE state
      r_done <= (r_state == S_DONE);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dz    <= 1'b0;
            r_ov    <= 1'b0;
            r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_r <= dividend[WIDTH-1];
            r_ovf   <= w_min && (divisor == '1);
            // ZERO path reuses r_mag to hold the raw dividend
            r_mag   <= w_dz_in ? dividend : w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_rem   <= '0;
            r_cnt   <= CW'(WIDTH);
          end
        end
        S_CALC: begin
          if (!w_diff[WIDTH]) begin
            r_rem <= w_diff[WIDTH-1:0];
            r_mag <= {r_mag[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
            r_mag <= {r_mag[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_quot <= r_neg_q ? (~r_mag + WIDTH'(1)) : r_mag;
          r_remo <= r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;
          r_ov   <= r_ovf;
        end
        S_ZERO: begin
          r_quot <= '1;
          r_remo <= r_mag;
          r_dz   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state == S_CALC) ||
                       (r_state == S_FIX)  ||
                       (r_state == S_ZERO);
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dz;
  assign overflow    = r_ov;

endmodule
